seg7_scan_encoder: RTL and testbench

//  Inverse of the 4-to-7 BCD segment decoder. Samples a time-multiplexed multi-digit
//  7-segment bus {a,b,c,d,e,f,g} plus one-hot digit strobe, glitch-filters it, encodes

---
 rtl/seg7_scan_encoder_pkg.sv | 57 +++++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg7_scan_encoder.sv | 148 ++++++++++++++
 tb/tb_seg7_scan_encoder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_scan_encoder_pkg.sv
// ============================================================================
// Module      : seg7_scan_encoder_pkg
// Description : Shared 7-segment constants (a..g, bit6=a .. bit0=g) and the
//               BCD codes used for blank and unrecognised patterns. The same
//               table drives the forward decoder and the scan encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seg7_scan_encoder_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_ILLEGAL = 4'hE;

  // Result of encoding one segment pattern.
  typedef struct packed {
    logic [3:0] bcd;
    logic       illegal;
  } seg7_code_t;

  // Map a segment pattern back to its digit; blank is a legal code.
  function automatic seg7_code_t seg7_encode(input logic [6:0] seg);
    seg7_code_t code;
    code.bcd     = BCD_ILLEGAL;
    code.illegal = 1'b1;
    case (seg)
      SEG_0:     begin code.bcd = 4'd0;      code.illegal = 1'b0; end
      SEG_1:     begin code.bcd = 4'd1;      code.illegal = 1'b0; end
      SEG_2:     begin code.bcd = 4'd2;      code.illegal = 1'b0; end
      SEG_3:     begin code.bcd = 4'd3;      code.illegal = 1'b0; end
      SEG_4:     begin code.bcd = 4'd4;      code.illegal = 1'b0; end
      SEG_5:     begin code.bcd = 4'd5;      code.illegal = 1'b0; end
      SEG_6:     begin code.bcd = 4'd6;      code.illegal = 1'b0; end
      SEG_7:     begin code.bcd = 4'd7;      code.illegal = 1'b0; end
      SEG_8:     begin code.bcd = 4'd8;      code.illegal = 1'b0; end
      SEG_9:     begin code.bcd = 4'd9;      code.illegal = 1'b0; end
      SEG_BLANK: begin code.bcd = BCD_BLANK; code.illegal = 1'b0; end
      default:   begin code.bcd = BCD_ILLEGAL; code.illegal = 1'b1; end
    endcase
    return code;
  endfunction

endpackage : seg7_scan_encoder_pkg

`default_nettype wire

// File: rtl/seg7_to_bcd.sv
// ============================================================================
// Module      : seg7_to_bcd
// Description : Combinational 7-segment pattern to BCD encoder. Blank maps to
//               4'hF (legal); anything outside the digit table maps to 4'hE
//               with illegal asserted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_to_bcd
  import seg7_scan_encoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       illegal
);

  seg7_code_t code;

  // Pure table lookup; no state.
  always_comb begin
    code    = seg7_encode(seg);
    bcd     = code.bcd;
    illegal = code.illegal;
  end

endmodule : seg7_to_bcd

`default_nettype wire

// File: rtl/seg7_scan_encoder.sv
// ============================================================================
// Module      : seg7_scan_encoder
// Description : Samples a multiplexed 7-segment bus plus one-hot digit
//               strobe, waits for STABLE_CYCLES identical samples, encodes
//               the pattern back to BCD into a shadow frame and publishes the
//               whole frame with a one-cycle frame_valid pulse once every
//               digit position has been captured.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_encoder
  import seg7_scan_encoder_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  frame_valid,
  output logic                  err,
  output logic [DIGITS-1:0]     err_mask
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Sample registers and stability counter
  logic [6:0]          s_seg_q,  s_seg_d;
  logic [DIGITS-1:0]   s_dig_q,  s_dig_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;

  // Frame assembly
  logic [DIGITS-1:0]   filled_q,     filled_d;
  logic [4*DIGITS-1:0] shadow_q,     shadow_d;
  logic [DIGITS-1:0]   shadow_err_q, shadow_err_d;

  // Published frame
  logic [4*DIGITS-1:0] bcd_out_q,     bcd_out_d;
  logic [DIGITS-1:0]   err_mask_q,    err_mask_d;
  logic                err_q,         err_d;
  logic                frame_valid_q, frame_valid_d;

  logic                dig_one_hot;
  logic                run_stable;
  logic                capture;
  logic                frame_done;
  logic [IDX_W-1:0]    dig_idx;
  logic [3:0]          enc_bcd;
  logic                enc_illegal;

  seg7_to_bcd u_enc (
    .seg     (seg_in),
    .bcd     (enc_bcd),
    .illegal (enc_illegal)
  );

  // Qualify the current input against the previous sample; only a single
  // active strobe can ever count toward a capture.
  always_comb begin
    dig_one_hot = ($countones(dig_en) == 1);
    run_stable  = dig_one_hot && (seg_in == s_seg_q) && (dig_en == s_dig_q);
    capture     = run_stable && (cnt_q == CNT_LAST);
    frame_done  = &filled_q;
  end

  // One-hot strobe to slot index (only meaningful when dig_en is one-hot).
  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_en[i]) begin
        dig_idx = IDX_W'(i);
      end
    end
  end

  // Next-state: sampling, saturating stability count, shadow writes and
  // frame publication. A capture on the publish edge starts the next frame.
  always_comb begin
    s_seg_d       = seg_in;
    s_dig_d       = dig_en;
    cnt_d         = '0;
    filled_d      = filled_q;
    shadow_d      = shadow_q;
    shadow_err_d  = shadow_err_q;
    bcd_out_d     = bcd_out_q;
    err_mask_d    = err_mask_q;
    err_d         = err_q;
    frame_valid_d = frame_done;

    if (run_stable) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
    end

    if (frame_done) begin
      bcd_out_d  = shadow_q;
      err_mask_d = shadow_err_q;
      err_d      = |shadow_err_q;
      filled_d   = '0;
    end

    if (capture) begin
      shadow_d[4*dig_idx +: 4] = enc_bcd;
      shadow_err_d[dig_idx]    = enc_illegal;
      filled_d[dig_idx]        = 1'b1;
    end
  end

  // State registers; reset discards any partially assembled frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg_q       <= '0;
      s_dig_q       <= '0;
      cnt_q         <= '0;
      filled_q      <= '0;
      shadow_q      <= '0;
      shadow_err_q  <= '0;
      bcd_out_q     <= '0;
      err_mask_q    <= '0;
      err_q         <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      s_seg_q       <= s_seg_d;
      s_dig_q       <= s_dig_d;
      cnt_q         <= cnt_d;
      filled_q      <= filled_d;
      shadow_q      <= shadow_d;
      shadow_err_q  <= shadow_err_d;
      bcd_out_q     <= bcd_out_d;
      err_mask_q    <= err_mask_d;
      err_q         <= err_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign bcd_out     = bcd_out_q;
  assign err_mask    = err_mask_q;
  assign err         = err_q;
  assign frame_valid = frame_valid_q;

endmodule : seg7_scan_encoder

`default_nettype wire

// File: tb/tb_seg7_scan_encoder.sv
// ============================================================================
// Module      : tb_seg7_scan_encoder
// Description : Self-checking bench for seg7_scan_encoder (DIGITS=4,
//               STABLE_CYCLES=3). A run-length reference model predicts
//               captures and frames; directed scenarios add fixed checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_encoder;

  localparam int DIGITS = 4;
  localparam int SC     = 3;

  localparam logic [6:0] PATS [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  logic                clk = 1'b0;
  logic                rst;
  logic [6:0]          seg_in;
  logic [DIGITS-1:0]   dig_en;
  logic [4*DIGITS-1:0] bcd_out;
  logic                frame_valid;
  logic                err;
  logic [DIGITS-1:0]   err_mask;

  int errors = 0;
  int checks = 0;
  int fv_count = 0;
  int step_no = 0;

  // Reference model: run length of identical presentations plus per-slot
  // contents of the frame being assembled and the last published frame.
  logic [6:0]        m_prev_s;
  logic [DIGITS-1:0] m_prev_d;
  bit                m_prev_valid;
  int                m_run;
  logic [3:0]        m_slot        [DIGITS];
  bit                m_slot_err    [DIGITS];
  bit                m_slot_filled [DIGITS];
  logic [15:0]       m_bcd;
  logic [3:0]        m_mask;
  logic              m_fv;

  seg7_scan_encoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_en      (dig_en),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .err         (err),
    .err_mask    (err_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ref_encode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (s == PATS[i]) return {1'b0, 4'(i)};
    end
    if (s == 7'b0000000) return 5'h0F;
    return 5'h1E;
  endfunction

  task automatic model_reset();
    m_prev_valid = 1'b0;
    m_prev_s = '0;
    m_prev_d = '0;
    m_run = 0;
    for (int i = 0; i < DIGITS; i++) begin
      m_slot[i] = 4'h0;
      m_slot_err[i] = 1'b0;
      m_slot_filled[i] = 1'b0;
    end
    m_bcd = '0;
    m_mask = '0;
    m_fv = 1'b0;
  endtask

  // Present one input for one clock edge, advance the model, compare.
  task automatic step(input logic [6:0] s, input logic [DIGITS-1:0] d);
    bit full;
    logic [4:0] enc;
    seg_in = s;
    dig_en = d;
    @(posedge clk);
    step_no++;
    if (m_prev_valid && s == m_prev_s && d == m_prev_d) m_run++;
    else m_run = 1;
    m_prev_valid = 1'b1;
    m_prev_s = s;
    m_prev_d = d;
    full = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (!m_slot_filled[i]) full = 1'b0;
    m_fv = full;
    if (full) begin
      for (int i = 0; i < DIGITS; i++) begin
        m_bcd[4*i +: 4] = m_slot[i];
        m_mask[i] = m_slot_err[i];
        m_slot_filled[i] = 1'b0;
      end
    end
    if ($countones(d) == 1 && m_run == SC + 1) begin
      enc = ref_encode(s);
      for (int i = 0; i < DIGITS; i++) begin
        if (d[i]) begin
          m_slot[i] = enc[3:0];
          m_slot_err[i] = enc[4];
          m_slot_filled[i] = 1'b1;
        end
      end
    end
    #1;
    if (frame_valid) fv_count++;
    checks++;
    if (frame_valid !== m_fv) begin
      errors++;
      $display("FAIL step%0d frame_valid: got %b expected %b", step_no, frame_valid, m_fv);
    end
    checks++;
    if (bcd_out !== m_bcd) begin
      errors++;
      $display("FAIL step%0d bcd_out: got %h expected %h", step_no, bcd_out, m_bcd);
    end
    checks++;
    if (err_mask !== m_mask) begin
      errors++;
      $display("FAIL step%0d err_mask: got %b expected %b", step_no, err_mask, m_mask);
    end
    checks++;
    if (err !== (|m_mask)) begin
      errors++;
      $display("FAIL step%0d err: got %b expected %b", step_no, err, |m_mask);
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [DIGITS-1:0] d, input int n);
    for (int k = 0; k < n; k++) step(s, d);
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if (bcd_out !== '0 || frame_valid !== 1'b0 || err !== 1'b0 || err_mask !== '0) begin
      errors++;
      $display("FAIL %s outputs: got bcd=%h fv=%b err=%b mask=%b expected all zero",
               tag, bcd_out, frame_valid, err, err_mask);
    end
  endtask

  task automatic check_frame(input string tag, input logic [15:0] exp_bcd,
                             input logic [3:0] exp_mask, input int exp_fv);
    checks++;
    if (bcd_out !== exp_bcd) begin
      errors++;
      $display("FAIL %s bcd_out: got %h expected %h", tag, bcd_out, exp_bcd);
    end
    checks++;
    if (err_mask !== exp_mask || err !== (|exp_mask)) begin
      errors++;
      $display("FAIL %s err: got mask=%b err=%b expected mask=%b err=%b",
               tag, err_mask, err, exp_mask, |exp_mask);
    end
    checks++;
    if (fv_count != exp_fv) begin
      errors++;
      $display("FAIL %s frame count: got %0d expected %0d", tag, fv_count, exp_fv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    seg_in = '0;
    dig_en = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    model_reset();
    step(7'b0, '0);
  endtask

  task automatic test_scan();
    fv_count = 0;
    hold(PATS[1], 4'b0001, 5);
    hold(PATS[2], 4'b0010, 5);
    hold(PATS[3], 4'b0100, 5);
    hold(PATS[4], 4'b1000, 5);
    check_frame("scan_1234", 16'h4321, 4'b0000, 1);
  endtask

  task automatic test_illegal();
    fv_count = 0;
    hold(PATS[5], 4'b0001, 5);
    hold(PATS[6], 4'b0010, 5);
    hold(7'b1001001, 4'b0100, 5);
    hold(PATS[7], 4'b1000, 5);
    check_frame("illegal", 16'h7E65, 4'b0100, 1);
    hold(PATS[0], 4'b0001, 5);
    hold(PATS[9], 4'b0010, 5);
    hold(PATS[8], 4'b0100, 5);
    hold(7'b0000000, 4'b1000, 5);
    check_frame("clean_after_illegal", 16'hF890, 4'b0000, 2);
  endtask

  task automatic test_glitch();
    fv_count = 0;
    hold(PATS[3], 4'b0001, 2);
    hold(PATS[5], 4'b0001, 2);
    hold(PATS[4], 4'b0010, 5);
    hold(PATS[6], 4'b0100, 5);
    hold(PATS[8], 4'b1000, 5);
    check_frame("glitch_no_frame", 16'hF890, 4'b0000, 0);
    hold(PATS[2], 4'b0001, 5);
    check_frame("glitch_frame", 16'h8642, 4'b0000, 1);
  endtask

  task automatic test_multihot();
    fv_count = 0;
    hold(PATS[8], 4'b0011, 10);
    hold(PATS[8], 4'b0000, 4);
    check_frame("multihot_no_frame", 16'h8642, 4'b0000, 0);
    hold(PATS[9], 4'b0001, 5);
    hold(PATS[8], 4'b0010, 5);
    hold(PATS[7], 4'b0100, 5);
    hold(PATS[6], 4'b1000, 5);
    check_frame("multihot_frame", 16'h6789, 4'b0000, 1);
  endtask

  task automatic test_recapture();
    fv_count = 0;
    hold(PATS[0], 4'b0001, 5);
    hold(PATS[7], 4'b0010, 5);
    hold(7'b0000000, 4'b0100, 5);
    hold(PATS[9], 4'b0010, 5);
    hold(PATS[3], 4'b1000, 5);
    check_frame("recapture", 16'h3F90, 4'b0000, 1);
  endtask

  task automatic test_reset_midframe();
    fv_count = 0;
    hold(PATS[1], 4'b0001, 5);
    hold(PATS[2], 4'b0010, 5);
    rst = 1'b1;
    #2;
    check_outputs_zero("midframe_reset");
    #2;
    rst = 1'b0;
    model_reset();
    hold(PATS[8], 4'b0001, 5);
    hold(PATS[8], 4'b0010, 5);
    hold(PATS[8], 4'b0100, 5);
    check_frame("reset_partial", 16'h0000, 4'b0000, 0);
    hold(PATS[8], 4'b1000, 5);
    check_frame("reset_8888", 16'h8888, 4'b0000, 1);
  endtask

  task automatic test_random();
    logic [6:0] s;
    logic [3:0] d;
    int r;
    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      s = PATS[$urandom_range(0, 9)];
      else if (r < 80) s = 7'b0000000;
      else             s = 7'($urandom);
      if ($urandom_range(0, 99) < 85) d = 4'(1 << $urandom_range(0, 3));
      else                            d = 4'($urandom);
      hold(s, d, $urandom_range(1, 6));
    end
  endtask

  task automatic test_back_to_back();
    // Minimal holds: each digit presented exactly SC+1 edges.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < DIGITS; i++) begin
        hold(PATS[(f + i) % 10], 4'(1 << i), SC + 1);
      end
    end
    hold(7'b0, 4'b0000, 3);
  endtask

  initial begin
    test_reset();
    test_scan();
    test_illegal();
    test_glitch();
    test_multihot();
    test_recapture();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seg7_scan_encoder

`default_nettype wire
